// File: rtl/bus_seg_ctl_pkg.sv
// Shared definitions for the bus-segment drive controller: segment state
// encoding, turnaround counter width and the default transceiver DIR level.
package bus_seg_ctl_pkg;

    typedef enum logic [1:0] {
        SEG_RX      = 2'd0,
        SEG_TURN_TX = 2'd1,
        SEG_TX      = 2'd2,
        SEG_TURN_RX = 2'd3
    } seg_state_e;

    localparam int CNT_W              = 4;
    localparam bit DIR_IN_LVL_DEFAULT = 1'b0;

endpackage

// File: rtl/bus_seg_fsm.sv
// One bus segment: turnaround sequencer with dead time, registered OE/DIR,
// registered output data and gated input capture with a sticky error flag.
module bus_seg_fsm
    import bus_seg_ctl_pkg::*;
#(
    parameter int SEG_W      = 8,
    parameter int DEAD_CYC   = 1,
    parameter bit DIR_IN_LVL = DIR_IN_LVL_DEFAULT
) (
    input  logic             clk_dot4x,
    input  logic             rst_n,
    input  logic             go,
    input  logic [SEG_W-1:0] dout,
    input  logic             cap_en,
    input  logic [SEG_W-1:0] bus_i,
    output logic [SEG_W-1:0] bus_o,
    output logic             bus_oe,
    output logic             dir_o,
    output logic [SEG_W-1:0] din_q,
    output logic             busy,
    output logic             cap_err
);

    localparam logic [CNT_W-1:0] DEAD_LD = CNT_W'(DEAD_CYC);

    seg_state_e       state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             load_data;

    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves a signal unassigned and no latch is inferred.
    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        unique case (state)
            SEG_RX: begin
                if (go) begin
                    next_state = SEG_TURN_TX;
                    cnt_next   = DEAD_LD;
                end
            end
            SEG_TURN_TX: begin
                if (cnt != '0) cnt_next = cnt - 1'b1;
                if (!go)             next_state = SEG_RX;
                else if (cnt == 4'd1) next_state = SEG_TX;
            end
            SEG_TX: begin
                if (!go) begin
                    next_state = SEG_TURN_RX;
                    cnt_next   = DEAD_LD;
                end
            end
            SEG_TURN_RX: begin
                if (cnt != '0) cnt_next = cnt - 1'b1;
                if (cnt == 4'd1) next_state = SEG_RX;
            end
            default: next_state = SEG_RX;
        endcase
        load_data = (next_state == SEG_TX) || (state == SEG_TX);
    end

    // NOTE: pad controls are flops fed from next_state, so they glitch-free
    // track the state register and all drop together on async reset.
    always_ff @(posedge clk_dot4x or negedge rst_n) begin
        if (!rst_n) begin
            state   <= SEG_RX;
            cnt     <= '0;
            bus_oe  <= 1'b0;
            dir_o   <= DIR_IN_LVL;
            busy    <= 1'b0;
            bus_o   <= '0;
            din_q   <= '0;
            cap_err <= 1'b0;
        end else begin
            state  <= next_state;
            cnt    <= cnt_next;
            bus_oe <= (next_state == SEG_TX);
            dir_o  <= (next_state == SEG_RX) ? DIR_IN_LVL : ~DIR_IN_LVL;
            busy   <= (next_state == SEG_TURN_TX) || (next_state == SEG_TURN_RX);
            if (load_data) bus_o <= dout;
            if (cap_en) begin
                if (state == SEG_RX) din_q   <= bus_i;
                else                 cap_err <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_seg_ctl.sv
// Bus-segment drive controller: NSEG independent segment sequencers sitting
// between the video core and the board-level tristate pads.
module bus_seg_ctl
    import bus_seg_ctl_pkg::*;
#(
    parameter int NSEG       = 3,
    parameter int SEG_W      = 8,
    parameter int DEAD_CYC   = 1,
    parameter bit DIR_IN_LVL = DIR_IN_LVL_DEFAULT
) (
    input  logic                  clk_dot4x,
    input  logic                  rst_n,
    input  logic [NSEG-1:0]       req_drive,
    input  logic                  force_tri,
    input  logic [NSEG*SEG_W-1:0] dout,
    input  logic [NSEG-1:0]       cap_en,
    input  logic [NSEG*SEG_W-1:0] bus_i,
    output logic [NSEG*SEG_W-1:0] bus_o,
    output logic [NSEG-1:0]       bus_oe,
    output logic [NSEG-1:0]       dir_o,
    output logic [NSEG*SEG_W-1:0] din_q,
    output logic [NSEG-1:0]       busy,
    output logic [NSEG-1:0]       cap_err
);

    logic [NSEG-1:0] go;

    for (genvar s = 0; s < NSEG; s++) begin : g_seg
        // force_tri overrides every request, so it looks like a dropped req.
        assign go[s] = req_drive[s] & ~force_tri;

        bus_seg_fsm #(
            .SEG_W     (SEG_W),
            .DEAD_CYC  (DEAD_CYC),
            .DIR_IN_LVL(DIR_IN_LVL)
        ) u_seg (
            .clk_dot4x(clk_dot4x),
            .rst_n    (rst_n),
            .go       (go[s]),
            .dout     (dout[s*SEG_W +: SEG_W]),
            .cap_en   (cap_en[s]),
            .bus_i    (bus_i[s*SEG_W +: SEG_W]),
            .bus_o    (bus_o[s*SEG_W +: SEG_W]),
            .bus_oe   (bus_oe[s]),
            .dir_o    (dir_o[s]),
            .din_q    (din_q[s*SEG_W +: SEG_W]),
            .busy     (busy[s]),
            .cap_err  (cap_err[s])
        );
    end

endmodule

// File: tb/tb_bus_seg_ctl.sv
// Self-checking bench for bus_seg_ctl: directed scenarios followed by random
// traffic, all compared against a timing-rule reference model.
module tb_bus_seg_ctl;

    localparam int NSEG     = 3;
    localparam int SEG_W    = 6;
    localparam int DEAD_CYC = 2;
    localparam int W        = NSEG * SEG_W;

    logic             clk_dot4x = 1'b0;
    logic             rst_n     = 1'b0;
    logic [NSEG-1:0]  req_drive = '0;
    logic             force_tri = 1'b0;
    logic [W-1:0]     dout      = '0;
    logic [NSEG-1:0]  cap_en    = '0;
    logic [W-1:0]     bus_i     = '0;
    logic [W-1:0]     bus_o;
    logic [NSEG-1:0]  bus_oe;
    logic [NSEG-1:0]  dir_o;
    logic [W-1:0]     din_q;
    logic [NSEG-1:0]  busy;
    logic [NSEG-1:0]  cap_err;

    int checks   = 0;
    int failures = 0;

    // Reference model: direction, enable, remaining dead cycles and the
    // direction a pending turnaround is heading.
    bit               m_out   [NSEG];
    bit               m_oe    [NSEG];
    int               m_timer [NSEG];
    bit               m_to_tx [NSEG];
    logic [SEG_W-1:0] m_bus   [NSEG];
    logic [SEG_W-1:0] m_din   [NSEG];
    bit               m_err   [NSEG];

    bus_seg_ctl #(
        .NSEG      (NSEG),
        .SEG_W     (SEG_W),
        .DEAD_CYC  (DEAD_CYC),
        .DIR_IN_LVL(1'b0)
    ) dut (
        .clk_dot4x(clk_dot4x),
        .rst_n    (rst_n),
        .req_drive(req_drive),
        .force_tri(force_tri),
        .dout     (dout),
        .cap_en   (cap_en),
        .bus_i    (bus_i),
        .bus_o    (bus_o),
        .bus_oe   (bus_oe),
        .dir_o    (dir_o),
        .din_q    (din_q),
        .busy     (busy),
        .cap_err  (cap_err)
    );

    always #5 clk_dot4x = ~clk_dot4x;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int s = 0; s < NSEG; s++) begin
            m_out[s]   = 1'b0;
            m_oe[s]    = 1'b0;
            m_timer[s] = 0;
            m_to_tx[s] = 1'b0;
            m_bus[s]   = '0;
            m_din[s]   = '0;
            m_err[s]   = 1'b0;
        end
    endtask

    // Applies one clock edge worth of rules using the inputs held at that edge.
    task automatic model_update();
        for (int s = 0; s < NSEG; s++) begin
            bit go;
            go = req_drive[s] && !force_tri;
            if (cap_en[s]) begin
                if (!m_out[s]) m_din[s] = bus_i[s*SEG_W +: SEG_W];
                else           m_err[s] = 1'b1;
            end
            if (m_timer[s] > 0) begin
                if (m_to_tx[s] && !go) begin
                    m_out[s]   = 1'b0;
                    m_timer[s] = 0;
                end else begin
                    m_timer[s]--;
                    if (m_timer[s] == 0) begin
                        if (m_to_tx[s]) begin
                            m_oe[s]  = 1'b1;
                            m_bus[s] = dout[s*SEG_W +: SEG_W];
                        end else begin
                            m_out[s] = 1'b0;
                        end
                    end
                end
            end else if (!m_out[s] && go) begin
                m_out[s]   = 1'b1;
                m_timer[s] = DEAD_CYC;
                m_to_tx[s] = 1'b1;
            end else if (m_oe[s]) begin
                if (go) begin
                    m_bus[s] = dout[s*SEG_W +: SEG_W];
                end else begin
                    m_oe[s]    = 1'b0;
                    m_timer[s] = DEAD_CYC;
                    m_to_tx[s] = 1'b0;
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        logic [NSEG-1:0] e_oe, e_dir, e_busy, e_err;
        logic [W-1:0]    e_din;
        for (int s = 0; s < NSEG; s++) begin
            e_oe[s]                 = m_oe[s];
            e_dir[s]                = m_out[s];
            e_busy[s]               = (m_timer[s] != 0);
            e_err[s]                = m_err[s];
            e_din[s*SEG_W +: SEG_W] = m_din[s];
        end
        check({tag, "/bus_oe"},  32'(bus_oe),  32'(e_oe));
        check({tag, "/dir_o"},   32'(dir_o),   32'(e_dir));
        check({tag, "/busy"},    32'(busy),    32'(e_busy));
        check({tag, "/din_q"},   32'(din_q),   32'(e_din));
        check({tag, "/cap_err"}, 32'(cap_err), 32'(e_err));
        for (int s = 0; s < NSEG; s++) begin
            if (m_oe[s]) check($sformatf("%s/bus_o%0d", tag, s),
                               32'(bus_o[s*SEG_W +: SEG_W]), 32'(m_bus[s]));
        end
    endtask

    task automatic step(input string tag);
        @(posedge clk_dot4x);
        model_update();
        @(negedge clk_dot4x);
        check_all(tag);
    endtask

    task automatic run(input int n, input string tag);
        for (int i = 0; i < n; i++) step(tag);
    endtask

    initial begin
        model_reset();
        #12;
        check_all("reset");
        @(negedge clk_dot4x);
        rst_n = 1'b1;

        // 1: segment 0 turns on after the dead time with its data valid
        dout      = 18'h0002A;
        req_drive = 3'b001;
        step("t1_dir");
        check("t1_dir0", 32'(dir_o[0]), 32'd1);
        check("t1_oe0_wait", 32'(bus_oe[0]), 32'd0);
        run(2, "t1");
        check("t1_oe0", 32'(bus_oe[0]), 32'd1);
        check("t1_bus0", 32'(bus_o[5:0]), 32'h2A);
        check("t1_others", 32'({bus_oe[2:1], dir_o[2:1]}), 32'd0);
        run(5, "t1_hold");

        // 2: release: OE drops first, DIR returns after the dead time
        req_drive = 3'b000;
        step("t2");
        check("t2_oe0", 32'(bus_oe[0]), 32'd0);
        check("t2_busy0_a", 32'(busy[0]), 32'd1);
        step("t2");
        check("t2_busy0_b", 32'(busy[0]), 32'd1);
        check("t2_dir0_held", 32'(dir_o[0]), 32'd1);
        step("t2");
        check("t2_dir0_in", 32'(dir_o[0]), 32'd0);

        // 3: one-cycle request aborts the turnaround without driving
        req_drive = 3'b010;
        step("t3");
        check("t3_dir1", 32'(dir_o[1]), 32'd1);
        req_drive = 3'b000;
        step("t3");
        check("t3_dir1_back", 32'(dir_o[1]), 32'd0);
        check("t3_oe1", 32'(bus_oe[1]), 32'd0);
        run(3, "t3_idle");

        // 4: force_tri releases every segment and holds them off
        req_drive = 3'b111;
        dout      = 18'h2D5A3;
        run(5, "t4_up");
        force_tri = 1'b1;
        step("t4_force");
        check("t4_oe_off", 32'(bus_oe), 32'd0);
        run(2, "t4_turn");
        check("t4_dir_in", 32'(dir_o), 32'd0);
        run(4, "t4_held");
        check("t4_still_off", 32'(bus_oe), 32'd0);
        force_tri = 1'b0;
        run(4, "t4_resume");

        // 5: capture in RX, then a rejected strobe while driving
        req_drive = 3'b000;
        run(4, "t5_down");
        bus_i  = 18'h00015;
        cap_en = 3'b001;
        step("t5_cap");
        check("t5_din0", 32'(din_q[5:0]), 32'h15);
        cap_en    = 3'b000;
        req_drive = 3'b001;
        run(4, "t5_up");
        bus_i  = 18'h0003F;
        cap_en = 3'b001;
        step("t5_bad");
        check("t5_err0", 32'(cap_err[0]), 32'd1);
        check("t5_din0_hold", 32'(din_q[5:0]), 32'h15);
        cap_en = 3'b000;
        run(2, "t5_sticky");

        // 6: asynchronous reset mid-TX
        req_drive = 3'b111;
        dout      = 18'h1B2C7;
        run(4, "t6_up");
        #1;
        rst_n = 1'b0;
        #1;
        check("t6_async_oe", 32'(bus_oe), 32'd0);
        check("t6_async_dir", 32'(dir_o), 32'd0);
        model_reset();
        @(negedge clk_dot4x);
        check_all("t6_in_reset");
        rst_n = 1'b1;
        run(2, "t6_restart");
        check("t6_no_early_oe", 32'(bus_oe), 32'd0);
        step("t6_restart");
        check("t6_oe_back", 32'(bus_oe), 32'd7);

        // random traffic against the model
        for (int i = 0; i < 400; i++) begin
            for (int s = 0; s < NSEG; s++)
                if ($urandom_range(0, 5) == 0) req_drive[s] = ~req_drive[s];
            force_tri = ($urandom_range(0, 19) == 0);
            for (int s = 0; s < NSEG; s++)
                cap_en[s] = ($urandom_range(0, 3) == 0);
            dout  = W'($urandom);
            bus_i = W'($urandom);
            step("rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
